// File: rtl/bpsk_symbol_modulator.sv
// BPSK symbol modulator: serialises DATA_WIDTH-bit words MSB first onto a square-wave
// carrier generated from clk by a fractional phase accumulator.
module bpsk_symbol_modulator #(
  parameter int CLOCK_IN      = 12_000_000,
  parameter int CLOCK_CARRIER = 64_000,
  parameter int DATA_WIDTH    = 8,
  parameter int CYCLE_COUNT   = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wave_out,
  output logic                  data_finish,
  output logic                  bit_strobe,
  output logic                  carrier_ref,
  output logic                  dbg_state_o
);

  localparam int ACC_W  = $clog2(CLOCK_IN) + 1;
  localparam int HALF_W = $clog2(2 * CYCLE_COUNT);
  localparam int IDX_W  = $clog2(DATA_WIDTH);

  localparam logic [ACC_W:0]    STEP      = (ACC_W + 1)'(2 * CLOCK_CARRIER);
  localparam logic [ACC_W:0]    LIMIT     = (ACC_W + 1)'(CLOCK_IN);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * CYCLE_COUNT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic {
    S_START = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  ref_q, ref_d;
  logic [HALF_W-1:0]     half_q, half_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  wave_q, wave_d;
  logic                  finish_q, finish_d;
  logic                  strobe_q, strobe_d;

  logic [ACC_W:0]        acc_sum;
  logic                  tick;

  // One extra bit on the sum so the compare against CLOCK_IN never wraps.
  assign acc_sum = {1'b0, acc_q} + STEP;
  assign tick    = (acc_sum >= LIMIT);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ref_d    = ref_q;
    half_d   = half_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    finish_d = 1'b0;
    strobe_d = 1'b0;

    case (state_q)
      S_START: begin
        sr_d     = data_in;
        idx_d    = '0;
        half_d   = '0;
        ref_d    = 1'b1;
        acc_d    = '0;
        strobe_d = 1'b1;
        state_d  = S_RUN;
      end

      S_RUN: begin
        acc_d = tick ? ACC_W'(acc_sum - LIMIT) : ACC_W'(acc_sum);
        if (tick) begin
          if (half_q == HALF_LAST) begin
            // Bit boundary: carrier restarts high so every bit opens on a fresh period.
            half_d   = '0;
            ref_d    = 1'b1;
            strobe_d = 1'b1;
            if (idx_q == IDX_LAST) begin
              sr_d  = data_in;
              idx_d = '0;
            end else begin
              sr_d     = sr_q << 1;
              idx_d    = idx_q + IDX_W'(1);
              finish_d = (idx_d == IDX_LAST);
            end
          end else begin
            ref_d  = ~ref_q;
            half_d = half_q + HALF_W'(1);
          end
        end
      end

      default: state_d = S_START;
    endcase

    wave_d = ref_d ^ ~sr_d[DATA_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= S_START;
      acc_q    <= '0;
      ref_q    <= 1'b0;
      half_q   <= '0;
      idx_q    <= '0;
      sr_q     <= '0;
      wave_q   <= 1'b0;
      finish_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ref_q    <= ref_d;
      half_q   <= half_d;
      idx_q    <= idx_d;
      sr_q     <= sr_d;
      wave_q   <= wave_d;
      finish_q <= finish_d;
      strobe_q <= strobe_d;
    end
  end

  assign wave_out    = wave_q;
  assign data_finish = finish_q;
  assign bit_strobe  = strobe_q;
  assign carrier_ref = ref_q;
  assign dbg_state_o = (state_q == S_RUN);

endmodule

// File: tb/tb_bpsk_symbol_modulator.sv
// Bench for bpsk_symbol_modulator: arithmetic reference model compared every cycle,
// decoded-word monitor, and directed/random scenarios at defaults plus a CYCLE_COUNT=4 instance.
module tb_bpsk_symbol_modulator;

  localparam int    DW    = 8;
  localparam int    CYC   = 2;
  localparam longint CLKF = 12_000_000;
  localparam longint CARF = 64_000;
  localparam longint HALVES = 2 * CYC;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DW-1:0] data_in = 8'hFF;
  logic          wave_out, data_finish, bit_strobe, carrier_ref, dbg_state;

  logic          n_rst4 = 1'b0;
  logic [DW-1:0] data_in4 = 8'h00;
  logic          wave4, finish4, strobe4, ref4, dbg_state4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit done4 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bpsk_symbol_modulator #(
    .CLOCK_IN(12_000_000), .CLOCK_CARRIER(64_000), .DATA_WIDTH(DW), .CYCLE_COUNT(CYC)
  ) dut (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .wave_out(wave_out),
    .data_finish(data_finish), .bit_strobe(bit_strobe), .carrier_ref(carrier_ref),
    .dbg_state_o(dbg_state)
  );

  bpsk_symbol_modulator #(
    .CLOCK_IN(12_000_000), .CLOCK_CARRIER(64_000), .DATA_WIDTH(DW), .CYCLE_COUNT(4)
  ) dut4 (
    .clk(clk), .n_rst(n_rst4), .data_in(data_in4), .wave_out(wave4),
    .data_finish(finish4), .bit_strobe(strobe4), .carrier_ref(ref4),
    .dbg_state_o(dbg_state4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: half-periods elapsed = floor(j*2*Fc/Fclk) edges after the start edge.
  bit           m_run = 1'b0;
  longint       m_j, m_h, h_new, b;
  int           bi;
  int           m_rst_events = 0;
  logic [DW-1:0] m_word;
  logic         e_wave = 1'b0, e_fin = 1'b0, e_str = 1'b0, e_ref = 1'b0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_run = 1'b0;
      m_rst_events++;
      e_wave = 1'b0; e_fin = 1'b0; e_str = 1'b0; e_ref = 1'b0;
    end else begin
      e_str = 1'b0;
      e_fin = 1'b0;
      if (!m_run) begin
        m_run = 1'b1; m_j = 0; m_h = 0; m_word = data_in; e_str = 1'b1;
      end else begin
        m_j++;
        h_new = (m_j * 2 * CARF) / CLKF;
        if (h_new != m_h && (h_new % HALVES) == 0) begin
          e_str = 1'b1;
          b = h_new / HALVES;
          if ((b % DW) == 0) m_word = data_in;
          if ((b % DW) == DW - 1) e_fin = 1'b1;
        end
        m_h = h_new;
      end
      b = m_h / HALVES;
      e_ref = ((m_h % 2) == 0);
      bi = DW - 1 - int'(b % DW);
      e_wave = e_ref ^ ~m_word[bi];
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("outputs{wave,finish,strobe,ref}", {28'd0, wave_out, data_finish, bit_strobe, carrier_ref},
          {28'd0, e_wave, e_fin, e_str, e_ref});
  end

  // Monitor: decode one bit per strobe from the first half-period level.
  logic [DW-1:0] dec_q[$];
  logic [DW-1:0] mon_sh = '0;
  int mon_cnt = 0, mon_last = -1, mon_rst_seen = 0, str_bad = 0, cnt_bad = 0;

  always @(negedge clk) begin
    if (mon_rst_seen != m_rst_events) begin
      mon_rst_seen = m_rst_events; mon_cnt = 0; mon_last = -1;
    end
    if (bit_strobe === 1'b1) begin
      mon_sh = {mon_sh[DW-2:0], ~(wave_out ^ carrier_ref)};
      mon_cnt++;
      if (mon_last >= 0 && (cyc - mon_last) != 375) str_bad++;
      mon_last = cyc;
      if (data_finish === 1'b1) begin
        if (mon_cnt == DW) dec_q.push_back(mon_sh);
        else cnt_bad++;
        mon_cnt = 0;
      end
    end
  end

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_finish(output int at);
    int k;
    k = 0;
    @(negedge clk);
    while (data_finish !== 1'b1 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (data_finish !== 1'b1) chk("wait_finish_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic wait_word(output logic [DW-1:0] w);
    int k;
    k = 0;
    while (dec_q.size() == 0 && k < 8000) begin
      @(negedge clk);
      k++;
    end
    if (dec_q.size() == 0) begin
      chk("wait_word_timeout", 32'd0, 32'd1);
      w = '0;
    end else begin
      w = dec_q.pop_front();
    end
  endtask

  // CYCLE_COUNT=4 instance with constant 8'h00.
  initial begin
    int f1, f2, f3, k, mism;
    wait_clks(20);
    n_rst4 = 1'b1;
    mism = 0; f1 = 0; f2 = 0; f3 = 0;
    for (int n = 0; n < 3; n++) begin
      k = 0;
      @(negedge clk);
      if (wave4 !== ~ref4) mism++;
      while (finish4 !== 1'b1 && k < 8000) begin
        @(negedge clk);
        if (wave4 !== ~ref4) mism++;
        k++;
      end
      if (finish4 !== 1'b1) chk("cc4_finish_timeout", 32'd0, 32'd1);
      if (n == 0) f1 = cyc; else if (n == 1) f2 = cyc; else f3 = cyc;
    end
    chk("cc4_word_period_1", 32'(f2 - f1), 32'd6000);
    chk("cc4_word_period_2", 32'(f3 - f2), 32'd6000);
    chk("cc4_wave_eq_not_ref", 32'(mism), 32'd0);
    done4 = 1'b1;
  end

  logic [DW-1:0] exp_q[$];

  initial begin
    int f1, f2, f3, k, edges, last_edge, sp_bad, mism;
    logic prev;
    logic [DW-1:0] w, got;

    // T1: reset held with data_in=FF
    @(negedge clk);
    chk_en = 1'b1;
    wait_clks(10);
    chk("t1_reset_outputs", {28'd0, wave_out, data_finish, bit_strobe, carrier_ref}, 32'd0);

    // T2: constant FF, wave follows carrier, 128 edges in 12000 clk
    n_rst = 1'b1;
    @(negedge clk);
    prev = wave_out; edges = 0; last_edge = 0; sp_bad = 0; mism = 0;
    for (int i = 1; i <= 12000; i++) begin
      @(negedge clk);
      if (wave_out !== carrier_ref) mism++;
      if (wave_out !== prev) begin
        edges++;
        if ((i - last_edge) != 93 && (i - last_edge) != 94) sp_bad++;
        last_edge = i;
      end
      prev = wave_out;
    end
    chk("t2_edge_count", 32'(edges), 32'd128);
    chk("t2_edge_spacing", 32'(sp_bad), 32'd0);
    chk("t2_wave_eq_ref", 32'(mism), 32'd0);

    // T3: constant 00, inverted carrier, finish every 3000 clk
    data_in = 8'h00;
    wait_finish(f1);
    wait_finish(f2);
    mism = 0; k = 0;
    if (wave_out !== ~carrier_ref) mism++;
    @(negedge clk);
    while (data_finish !== 1'b1 && k < 4000) begin
      if (wave_out !== ~carrier_ref) mism++;
      @(negedge clk);
      k++;
    end
    f3 = cyc;
    chk("t3_finish_period_1", 32'(f2 - f1), 32'd3000);
    chk("t3_finish_period_2", 32'(f3 - f2), 32'd3000);
    chk("t3_wave_eq_not_ref", 32'(mism), 32'd0);

    // T4: A5 decodes bit by bit
    data_in = 8'hA5;
    @(negedge clk);
    dec_q.delete();
    wait_word(got);
    chk("t4_decode_a5", {24'd0, got}, 32'h0000_00A5);

    // T5: mid-word change ignored; change 10 clk after finish is taken
    wait_clks(1000);
    data_in = 8'h3C;
    wait_finish(f1);
    wait_clks(10);
    data_in = 8'h0F;
    wait_word(got);
    chk("t5_word_in_flight", {24'd0, got}, 32'h0000_00A5);
    wait_word(got);
    chk("t5_next_word", {24'd0, got}, 32'h0000_000F);

    // Random words with junk written mid-word
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom_range(0, 255));
      data_in = w;
      exp_q.push_back(w);
      wait_clks($urandom_range(400, 2500));
      data_in = 8'($urandom_range(0, 255));
      wait_finish(f1);
      wait_clks($urandom_range(1, 300));
    end
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      wait_word(got);
      chk("rand_word", {24'd0, got}, {24'd0, w});
    end

    // T6: one-cycle reset in the middle of bit 4, restart re-samples data_in
    data_in = 8'h77;
    wait_finish(f1);
    wait_clks(375 + 4 * 375 + 187);
    data_in = 8'h5A;
    n_rst = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", {28'd0, wave_out, data_finish, bit_strobe, carrier_ref}, 32'd0);
    n_rst = 1'b1;
    dec_q.delete();
    wait_word(got);
    chk("t6_restart_word", {24'd0, got}, 32'h0000_005A);

    chk("strobe_spacing_375", 32'(str_bad), 32'd0);
    chk("strobes_per_word_8", 32'(cnt_bad), 32'd0);

    k = 0;
    while (!done4 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    if (!done4) chk("cc4_done_timeout", 32'd0, 32'd1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
